// File: rtl/wb_bram_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone BlockRAM arbiter.
//   gnt_e           : one-hot grant encoding, which is also the FSM state
//                     (GNT_IDLE = 00, GNT_M0 = 01, GNT_M1 = 10)
//   CNT_W           : width of the watchdog counter
//   TIMEOUT_DEFAULT : default watchdog limit in cycles of unacknowledged strobe
package wb_bram_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_e;

  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_bram_arbiter_watchdog.sv
// Per-grant watchdog for the BlockRAM arbiter.
// Counts cycles of slave strobe without acknowledge and raises err_o for one
// cycle when the count reaches TIMEOUT; the counter then restarts.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-low reset
//   gnt_chg_i     : grant changes at the next edge (restarts the count)
//   stb_i         : slave strobe as driven by the arbiter
//   ack_i         : slave acknowledge (restarts the count)
//   err_o         : timeout pulse, one cycle
module wb_arb_watchdog
  import wb_bram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic gnt_chg_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic err_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hit;

  assign hit = (cnt_q == LIMIT);

  // An ack in the same cycle as a hit wins: the transfer completed, so no error.
  assign err_o = hit & ~ack_i;

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_chg_i || ack_i || hit) begin
      cnt_d = '0;
    end else if (stb_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter in front of a single-port BlockRAM slave.
// A master keeps the slave for its whole cyc-framed bus cycle; the slave ack
// is returned only to the granted master. A watchdog flags stuck transfers.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   mN_adr_i/dat_i/sel_i  : master N address, write data, byte selects
//   mN_stb_i/cyc_i/we_i   : master N Wishbone control
//   mN_dat_o              : slave read data (shared by both masters)
//   mN_ack_o / mN_err_o   : ack gated by grant N / watchdog error pulse
//   s_*_o, s_dat_i,s_ack_i: slave side of the bus
//   gnt_o                 : one-hot current grant, 00 = idle
// Configuration:
//   WB_BRAM_ARB_RR_EN defined   -> round-robin tie break (m0 wins first tie)
//   WB_BRAM_ARB_RR_EN undefined -> fixed priority, m0 wins every tie
module wb_bram_arbiter
  import wb_bram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  gnt_e gnt_q;
  gnt_e gnt_d;
  logic arb_en;
  logic tie_m1;
  logic gnt_chg;
  logic wd_err;

  // Tie-break policy: tie_m1 selects master 1 when both request together.
`ifdef WB_BRAM_ARB_RR_EN
  // last_q = 1 means master 1 was granted most recently; reset value makes
  // master 0 win the first tie.
  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (gnt_chg) begin
      if (gnt_d == GNT_M0) begin
        last_d = 1'b0;
      end else if (gnt_d == GNT_M1) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign tie_m1 = ~last_q;
`else
  assign tie_m1 = 1'b0;
`endif

  // State register: the one-hot grant itself.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_q <= GNT_IDLE;
    end else begin
      gnt_q <= gnt_d;
    end
  end

  // Next state: arbitrate only when idle or when the owner has dropped cyc;
  // a master holding cyc is never preempted, whatever its stb does.
  always_comb begin
    gnt_d  = gnt_q;
    arb_en = 1'b1;
    case (gnt_q)
      GNT_M0:  arb_en = ~m0_cyc_i;
      GNT_M1:  arb_en = ~m1_cyc_i;
      default: arb_en = 1'b1;
    endcase
    if (arb_en) begin
      case ({m1_cyc_i, m0_cyc_i})
        2'b01:   gnt_d = GNT_M0;
        2'b10:   gnt_d = GNT_M1;
        2'b11:   gnt_d = tie_m1 ? GNT_M1 : GNT_M0;
        default: gnt_d = GNT_IDLE;
      endcase
    end
  end

  assign gnt_chg = (gnt_d != gnt_q);

  // Outputs: slave mux follows the registered grant combinationally, so on a
  // handover the slave sees the old owner's dropped cyc for one cycle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    case (gnt_q)
      GNT_M0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_stb_o = m0_stb_i;
        s_cyc_o = m0_cyc_i;
        s_we_o  = m0_we_i;
      end
      GNT_M1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_stb_o = m1_stb_i;
        s_cyc_o = m1_cyc_i;
        s_we_o  = m1_we_i;
      end
      default: ;
    endcase
  end

  assign gnt_o    = gnt_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt_o[0];
  assign m1_ack_o = s_ack_i & gnt_o[1];
  assign m0_err_o = wd_err & gnt_o[0];
  assign m1_err_o = wd_err & gnt_o[1];

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .gnt_chg_i (gnt_chg),
    .stb_i     (s_stb_o),
    .ack_i     (s_ack_i),
    .err_o     (wd_err)
  );

endmodule

// File: doc/wb_bram_arbiter.md
# wb_bram_arbiter

Two-master Wishbone arbiter that shares one single-port Wishbone BlockRAM slave between two requesters, e.g. the LM32 instruction and data buses. It grants the slave port to one master for a whole bus cycle (`cyc`-framed) and routes the slave's `ack` back only to the granted master. A per-grant watchdog reports stuck transfers with `err`. The block sits between the CPU bus masters and the BlockRAM.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles of `s_stb_o` high without `s_ack_i` before `err` pulses. Range 1..255.

Ports (the `mN_` lines exist once per master, N = 0, 1):
- `clk_i`  in  1  single clock; all state on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low (0 = reset).
- `mN_adr_i`  in  32  master N address.
- `mN_dat_i`  in  32  master N write data.
- `mN_dat_o`  out  32  read data; `s_dat_i` fanned out to both masters.
- `mN_sel_i`  in  4  byte selects.
- `mN_stb_i`, `mN_cyc_i`, `mN_we_i`  in  1 each  Wishbone strobe, cycle and write enable.
- `mN_ack_o`  out  1  `s_ack_i` gated by grant N.
- `mN_err_o`  out  1  watchdog error, one-cycle pulse.
- `s_adr_o`, `s_dat_o`  out  32 each  to the slave.
- `s_sel_o`  out  4  to the slave.
- `s_stb_o`, `s_cyc_o`, `s_we_o`  out  1 each  to the slave.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`  in  1  slave acknowledge.
- `gnt_o`  out  2  one-hot current grant; 00 = idle.

## Operation
- FSM states: IDLE, GNT0, GNT1, held in a registered one-hot grant.
- Arbitration runs at every edge where the FSM is in IDLE, or in GNTx with `mx_cyc_i` low.
  - Candidates: masters with `cyc` high.
  - None → IDLE.
  - One → grant it.
  - Both → policy winner (see Configuration).
- GNTx with `mx_cyc_i` high → stay in GNTx. No preemption; `stb` toggling inside the cycle does not release the grant.
- Direct handover GNT0→GNT1 is legal. The slave still sees `cyc` low for one cycle, because `s_cyc_o` follows the old master's dropped `cyc`. This clears the BRAM's toggling ack register.
- Slave-side mux:
  - In GNTx, `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_stb_o`, `s_cyc_o` and `s_we_o` equal master x's inputs, combinationally.
  - In IDLE, all slave outputs are 0.
- Ack routing: `mx_ack_o = s_ack_i & gnt_o[x]`. The non-granted master's ack is always 0.
- Watchdog:
  - 8-bit counter. It clears on reset, on any grant change, and on `s_ack_i`.
  - It increments while `s_stb_o & ~s_ack_i`.
  - When it equals `TIMEOUT`: `mx_err_o` pulses for 1 cycle for the granted master and the counter clears. The grant is not released.
- Reset values: grant 00 (IDLE), all `s_*` outputs 0, `mN_ack_o` 0, `mN_err_o` 0, counter 0, round-robin pointer "last = 1".

## Timing
- Grant latency: `cyc` rises in cycle n while idle → `gnt_o` and slave signals valid in cycle n+1.
- Slave path: zero added latency after grant. Ack to the master is combinational from `s_ack_i`.
- With the BlockRAM, each access takes 2 cycles: ack on every second cycle while `stb` is held.
- Release: master drops `cyc` in cycle k → new grant (or IDLE) in k+1.
- Both masters request in the same cycle: exactly one grant; the other master waits with ack 0.
- Reset asserted mid-transfer: the grant drops immediately (asynchronously). `s_cyc_o` and `s_stb_o` go to 0 in the same cycle. Any in-flight ack is not forwarded.
- `err` and `ack` in the same cycle: impossible, because ack clears the counter first.

## Configuration
- `WB_BRAM_ARB_RR_EN` defined: round-robin.
  - On a tie, the master not granted most recently wins.
  - The pointer updates on each new grant.
  - After reset, m0 wins the first tie.
- Undefined: fixed priority; m0 always wins a tie and no pointer register exists.
- Either policy only acts at arbitration points; neither preempts.

## Structure
- Shared package: grant encodings (`GNT_IDLE`, `GNT_M0`, `GNT_M1`), counter width, default `TIMEOUT`.
- One sub-module, `wb_arb_watchdog`: counter, compare, err pulse. It takes the grant-change, stb and ack inputs.
- Mux, FSM and policy stay in the top module.

## Test plan
- m0 only: write 0xDEADBEEF to 0x10, then read 0x10 → `gnt_o` = 01 one cycle after `cyc`, `m0_dat_o` = 0xDEADBEEF, `m1_ack_o` stays 0.
- m0 and m1 raise `cyc` in the same cycle:
  - Without the macro → m0 served first, m1 granted 1 cycle after m0 drops `cyc`.
  - With the macro, on a repeat tie → m1 served first on the second tie.
- Back-to-back handover: m0 drops `cyc` at cycle k with m1 pending → `gnt_o` = 10 at k+1, slave sees `cyc` low in cycle k, m1 gets its first ack 2 cycles after grant.
- Watchdog: slave model never acks, `TIMEOUT` = 4 → `m0_err_o` pulses exactly once per 5 cycles of `stb` (4 counts plus the clear cycle), grant held.
- Reset pulse low mid-burst of m1 → `gnt_o` = 00, `s_cyc_o` = 0 asynchronously. After release with m0 requesting, m0 is granted first under both policies.
- m1 holds `cyc` with `stb` toggling for 10 cycles while m0 requests → m0 never granted until m1 drops `cyc`.
